// File: rtl/hostsystem_stream_writer.sv
// hostsystem_stream_writer: CSR-programmed stream-to-memory writer with completion interrupt
module hostsystem_stream_writer #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        csr_address,
   input  logic              csr_write,
   input  logic              csr_read,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   input  logic              snk_valid,
   output logic              snk_ready,
   input  logic [31:0]       snk_data,
   input  logic              snk_endofpacket,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   output logic              irq
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] start, ptr;
   logic [11:0] length, remaining, count;
   logic irq_en, done, early_eop;
   logic busy, beat, ctl_wr, go, abort, last, eop_early, done_clr;
   logic [31:0] rdata;
   assign busy = state != S_IDLE;
   assign snk_ready = state == S_RUN;
   assign beat = snk_valid && snk_ready;
   assign ctl_wr = csr_write && csr_address == 2'd2;
   assign go = ctl_wr && csr_writedata[0] && !busy;
   assign abort = ctl_wr && csr_writedata[2];
   assign last = beat && remaining == 12'd1;
   assign eop_early = beat && snk_endofpacket && remaining > 12'd1;
   assign done_clr = csr_write && csr_address == 2'd3 && csr_writedata[1];
   assign mem_byteenable = 4'hF;
   assign mem_clken = 1'b1;
   assign irq = done & irq_en;
   always_comb begin
      state_n = state;
      if (state == S_IDLE && go)
         state_n = (length != 12'd0) ? S_RUN : S_DONE;
      else if (state == S_RUN && (last || eop_early || abort))
         state_n = S_DONE;
      else if (state == S_DONE)
         state_n = S_IDLE;
   end
   always_comb
      rdata = csr_address == 2'd0 ? 32'(start) :
              csr_address == 2'd1 ? 32'(length) :
              csr_address == 2'd2 ? {30'b0, irq_en, 1'b0} :
                                    {4'b0, count, 13'b0, early_eop, done, busy};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= S_IDLE;
      else          state <= state_n;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         start          <= '0;
         length         <= '0;
         irq_en         <= 1'b0;
         done           <= 1'b0;
         early_eop      <= 1'b0;
         count          <= '0;
         ptr            <= '0;
         remaining      <= '0;
         mem_write      <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
         csr_readdata   <= '0;
      end else begin
         if (csr_write && csr_address == 2'd0 && !busy) start <= csr_writedata[ADDR_W-1:0];
         if (csr_write && csr_address == 2'd1 && !busy) length <= csr_writedata[11:0];
         if (ctl_wr) irq_en <= csr_writedata[1];
         if (go && length != 12'd0) begin
            ptr       <= start;
            remaining <= length;
            count     <= '0;
            early_eop <= 1'b0;
         end else if (beat) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 12'd1;
            count     <= count + 12'd1;
         end
         if (eop_early) early_eop <= 1'b1;
         // setting DONE takes priority over a same-cycle write-1-to-clear
         done           <= (state != S_DONE && state_n == S_DONE) || (done && !done_clr);
         mem_write      <= beat;
         mem_chipselect <= beat;
         if (beat) begin
            mem_address   <= ptr;
            mem_writedata <= snk_data;
         end
         csr_readdata <= csr_read ? rdata : '0;
      end
endmodule

// File: tb/tb_hostsystem_stream_writer.sv
// tb_hostsystem_stream_writer: directed scenario checks for hostsystem_stream_writer
module tb_hostsystem_stream_writer;
   logic clk = 0, reset_n = 0;
   logic [1:0] csr_address = 0;
   logic csr_write = 0, csr_read = 0;
   logic [31:0] csr_writedata = 0, csr_readdata;
   logic snk_valid = 0, snk_ready, snk_endofpacket = 0;
   logic [31:0] snk_data = 0;
   logic [10:0] mem_address;
   logic [3:0] mem_byteenable;
   logic mem_chipselect, mem_write, mem_clken, irq;
   logic [31:0] mem_writedata;
   logic [31:0] rd;
   int tests = 0, fails = 0;

   hostsystem_stream_writer #(.ADDR_W(11)) dut (
      .clk(clk), .reset_n(reset_n),
      .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
      .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
      .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
      .snk_endofpacket(snk_endofpacket),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1;
      @(negedge clk);
      csr_write = 0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      csr_address = a; csr_read = 1;
      @(negedge clk);
      csr_read = 0;
      d = csr_readdata;
   endtask

   // drives one beat and expects its memory write exactly one cycle later
   task automatic beat(input logic [31:0] d, input logic eop, input logic [10:0] a);
      snk_valid = 1; snk_data = d; snk_endofpacket = eop;
      tests++;
      if (snk_ready !== 1'b1) begin fails++; $display("FAIL beat_ready got %b exp 1", snk_ready); end
      @(negedge clk);
      snk_valid = 0; snk_endofpacket = 0;
      tests++;
      if ({mem_write, mem_chipselect, mem_address, mem_writedata} !== {2'b11, a, d}) begin
         fails++;
         $display("FAIL beat_write got we=%b cs=%b a=%h d=%h exp a=%h d=%h",
                  mem_write, mem_chipselect, mem_address, mem_writedata, a, d);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if ({snk_ready, mem_write, mem_chipselect, mem_address, mem_writedata, csr_readdata, irq, mem_byteenable, mem_clken}
          !== {3'b000, 11'h0, 32'h0, 32'h0, 1'b0, 4'hF, 1'b1}) begin
         fails++; $display("FAIL reset_outputs got a=%h d=%h we=%b be=%h ck=%b", mem_address, mem_writedata, mem_write, mem_byteenable, mem_clken);
      end
      reset_n = 1;
      @(negedge clk);
      csr_rd(3, rd);
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 0", rd); end
   endtask

   task automatic test_basic();
      csr_wr(0, 32'h010); csr_wr(1, 4); csr_wr(2, 1);
      for (int i = 0; i < 4; i++) beat(32'hA0 + i, 0, 11'h010 + 11'(i));
      @(negedge clk);
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL basic_no_extra_write got %b exp 0", mem_write); end
      csr_rd(3, rd);
      tests++;
      if (rd !== 32'h0004_0002) begin fails++; $display("FAIL basic_status got %h exp 00040002", rd); end
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq got %b exp 0", irq); end
      csr_wr(3, 2);
   endtask

   task automatic test_wrap();
      csr_wr(0, 32'h7FE); csr_wr(1, 3); csr_wr(2, 3);
      beat(32'h11, 0, 11'h7FE); beat(32'h22, 0, 11'h7FF); beat(32'h33, 0, 11'h000);
      @(negedge clk);
      tests++;
      if (irq !== 1'b1) begin fails++; $display("FAIL wrap_irq_set got %b exp 1", irq); end
      csr_rd(2, rd);
      tests++;
      if (rd !== 32'h2) begin fails++; $display("FAIL wrap_ctrl_read got %h exp 2", rd); end
      csr_wr(3, 2);
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL wrap_irq_clear got %b exp 0", irq); end
      csr_wr(2, 0);
   endtask

   task automatic test_early_eop();
      csr_wr(0, 32'h100); csr_wr(1, 8); csr_wr(2, 1);
      beat(32'hB0, 0, 11'h100); beat(32'hB1, 0, 11'h101); beat(32'hB2, 1, 11'h102);
      snk_valid = 1;
      tests++;
      if (snk_ready !== 1'b0) begin fails++; $display("FAIL eop_ready_after got %b exp 0", snk_ready); end
      @(negedge clk);
      snk_valid = 0;
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL eop_no_4th_write got %b exp 0", mem_write); end
      csr_rd(3, rd);
      tests++;
      if (rd !== 32'h0003_0006) begin fails++; $display("FAIL eop_status got %h exp 00030006", rd); end
      csr_wr(3, 2);
   endtask

   task automatic test_zero_len_busy();
      csr_wr(1, 0); csr_wr(2, 1);
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL zero_write_a got %b exp 0", mem_write); end
      @(negedge clk);
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL zero_write_b got %b exp 0", mem_write); end
      csr_rd(3, rd);
      tests++;
      if ((rd & 32'h3) !== 32'h2) begin fails++; $display("FAIL zero_done got %h exp done=1 busy=0", rd & 32'h3); end
      csr_wr(3, 2);
      csr_wr(0, 32'h020); csr_wr(1, 4); csr_wr(2, 1);
      csr_wr(0, 32'h055); csr_wr(1, 7);
      for (int i = 0; i < 4; i++) beat(32'hC0 + i, 0, 11'h020 + 11'(i));
      @(negedge clk);
      csr_rd(0, rd);
      tests++;
      if (rd !== 32'h020) begin fails++; $display("FAIL busy_start got %h exp 020", rd); end
      csr_rd(1, rd);
      tests++;
      if (rd !== 32'h4) begin fails++; $display("FAIL busy_length got %h exp 4", rd); end
      csr_wr(3, 2);
   endtask

   task automatic test_abort();
      csr_wr(0, 32'h200); csr_wr(1, 10); csr_wr(2, 1);
      beat(32'hD0, 0, 11'h200); beat(32'hD1, 0, 11'h201);
      csr_wr(2, 4);
      snk_valid = 1;
      tests++;
      if (snk_ready !== 1'b0) begin fails++; $display("FAIL abort_ready got %b exp 0", snk_ready); end
      @(negedge clk);
      snk_valid = 0;
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL abort_no_write got %b exp 0", mem_write); end
      csr_rd(3, rd);
      tests++;
      if (rd !== 32'h0002_0002) begin fails++; $display("FAIL abort_status got %h exp 00020002", rd); end
      csr_wr(3, 2);
   endtask

   task automatic test_gapped();
      csr_wr(0, 32'h300); csr_wr(1, 3); csr_wr(2, 1);
      for (int i = 0; i < 3; i++) begin
         beat(32'hE0 + i, 0, 11'h300 + 11'(i));
         @(negedge clk);
         tests++;
         if (mem_write !== 1'b0) begin fails++; $display("FAIL gap_no_write %0d got %b exp 0", i, mem_write); end
      end
      csr_rd(3, rd);
      tests++;
      if (rd !== 32'h0003_0002) begin fails++; $display("FAIL gap_status got %h exp 00030002", rd); end
      csr_wr(3, 2);
   endtask

   task automatic test_reset_mid_run();
      csr_wr(0, 32'h400); csr_wr(1, 5); csr_wr(2, 3);
      snk_valid = 1; snk_data = 32'hF00D;
      @(posedge clk); #1;
      tests++;
      if (mem_write !== 1'b1) begin fails++; $display("FAIL rst_pre_write got %b exp 1", mem_write); end
      reset_n = 0;
      #1;
      tests++;
      if ({snk_ready, mem_write, mem_chipselect, mem_address, mem_writedata, csr_readdata, irq, mem_byteenable, mem_clken}
          !== {3'b000, 11'h0, 32'h0, 32'h0, 1'b0, 4'hF, 1'b1}) begin
         fails++; $display("FAIL rst_mid_outputs got rdy=%b we=%b cs=%b a=%h d=%h", snk_ready, mem_write, mem_chipselect, mem_address, mem_writedata);
      end
      @(negedge clk);
      snk_valid = 0; reset_n = 1;
      @(negedge clk);
      tests++;
      if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_dropped_write got %b exp 0", mem_write); end
      csr_rd(0, rd);
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL rst_start got %h exp 0", rd); end
      csr_rd(2, rd);
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL rst_irq_en got %h exp 0", rd); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_early_eop();
      test_zero_len_busy();
      test_abort();
      test_gapped();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
